gate_truth_checker: RTL
=======================

# gate_truth_checker

Sequential stimulus-and-check stage wrapped around a small combinational gate under test, such as the NOR-built 2-input OR. It drives every input combination onto the gate and waits a programmable settle time. It then samples the gate output and compares it against a parameterised truth table. It reports error count, first failing vector and a pass flag, replacing hand-written `$monitor` benches with a self-checking, synthesizable harness.

## Interface
- `N_IN`, 2, number of gate inputs (1..4)
- `SETTLE`, 2, cycles each vector is held before sampling (≥1)
- `TRUTH`, 4'b1110, expected output per vector; bit i = expected Z for stim == i; width 2^N_IN; default is 2-input OR
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin sweep; sampled only in IDLE
- `dut_z`  in  1  output of gate under test
- `stim`  out  N_IN  inputs driven to gate under test
- `busy`  out  1  high in SETTLE, CHECK, DONE
- `done`  out  1  one-cycle pulse at end of sweep
- `pass`  out  1  1 when last sweep had zero mismatches; held until next start
- `err_cnt`  out  N_IN+1  mismatch count of current/last sweep
- `fail_vec`  out  N_IN  first failing stim value
- `fail_vld`  out  1  fail_vec is valid

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: on `start`=1, clear err_cnt, fail_vld, fail_vec, pass; stim←0; load settle counter with SETTLE-1; go SETTLE.
- SETTLE: hold stim. If counter==0 go CHECK, else decrement.
- CHECK: compare `dut_z` with TRUTH[stim]. On mismatch, err_cnt+1. On first mismatch, fail_vec←stim and fail_vld←1.
  - If stim == 2^N_IN-1: go DONE.
  - Otherwise: stim+1, reload counter, go SETTLE.
- DONE: done=1 for this cycle; pass←(final err_cnt==0); go IDLE.
- err_cnt width N_IN+1 holds max 2^N_IN; no wrap or saturation needed.
- `start` outside IDLE is ignored, including in DONE; no queuing.
- `dut_z` is treated as combinational from stim; it is not synchronised.
- Reset mid-sweep aborts immediately. All outputs take reset values and the state becomes IDLE.

## Timing
- Reset values: stim=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, fail_vld=0.
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in SETTLE plus 1 in CHECK.
- Latency: `start` sampled at edge 0; done is high during cycle 2^N_IN·(SETTLE+1)+1. For defaults this is cycle 13.
- err_cnt and fail_* update on the edge ending the CHECK cycle.
- pass updates on the edge ending DONE, coincident with done falling.
- Back-to-back sweep: earliest new start is sampled the cycle after DONE.

## Configuration
- `GATE_TRUTH_CHECKER_STOP_ON_FAIL_EN` defined:
  - CHECK with a mismatch goes directly to DONE.
  - err_cnt ≤1 and stim freezes at the failing vector.
- Macro undefined: the full sweep always runs to the last vector regardless of mismatches.

## Structure
- Shared package `gate_check_pkg`: state encoding constants (IDLE=2'd0, SETTLE=2'd1, CHECK=2'd2, DONE=2'd3) and standard TRUTH constants for OR2, AND2, NOR2, NAND2, XOR2.
- One natural sub-module: `settle_timer`, a loadable down-counter with a `zero` output, instantiated once.
- The rest is FSM and datapath in the top module.

## Test plan
1. Correct OR2 (NOR-based) as DUT, defaults, start pulse:
   - stim steps 0,1,2,3.
   - done in cycle 13; pass=1, err_cnt=0, fail_vld=0.
2. dut_z tied to 0, TRUTH=OR:
   - err_cnt=3, fail_vec=2'b01, fail_vld=1, pass=0, done in cycle 13.
3. AND2 as DUT, TRUTH=OR:
   - mismatches at 01 and 10 only.
   - err_cnt=2, fail_vec=2'b01, pass=0.
4. `start` reasserted during SETTLE of vector 2 and again in DONE:
   - both are ignored.
   - Single done pulse; stim sequence uninterrupted.
5. rst_n pulled low during CHECK of vector 1, then released with `start`:
   - all outputs return to reset values asynchronously.
   - The fresh sweep completes with pass=1 for a correct OR2.
6. Macro defined, dut_z tied to 0, TRUTH=OR:
   - vector 0 passes; vector 1 mismatches in its CHECK (cycle 6).
   - done in cycle 7; err_cnt=1, fail_vec=2'b01, stim=1.

Source files
------------

// File: rtl/gate_check_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : gate_check_pkg                                           |
// | Description : Shared FSM state encoding and standard 2-input gate      |
// |               truth tables for the gate truth checker.                 |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package gate_check_pkg;

   // State encoding, fixed so that state values are stable across builds
   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_settle = 2'd1;
   localparam logic [1:0] c_st_check  = 2'd2;
   localparam logic [1:0] c_st_done   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = c_st_idle,
      ST_SETTLE = c_st_settle,
      ST_CHECK  = c_st_check,
      ST_DONE   = c_st_done
   } state_t;

   // Truth tables: bit i is the expected output when the stimulus equals i
   localparam logic [3:0] c_truth_or2   = 4'b1110;
   localparam logic [3:0] c_truth_and2  = 4'b1000;
   localparam logic [3:0] c_truth_nor2  = 4'b0001;
   localparam logic [3:0] c_truth_nand2 = 4'b0111;
   localparam logic [3:0] c_truth_xor2  = 4'b0110;

endpackage : gate_check_pkg
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : settle_timer                                             |
// | Description : Loadable down-counter; zero flags the end of the settle  |
// |               window for the current stimulus vector.                  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module settle_timer #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] r_count;

   // Load has priority; decrement never wraps below zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign zero = (r_count == '0);

endmodule : settle_timer
`default_nettype wire

// File: rtl/gate_truth_checker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : gate_truth_checker                                       |
// | Description : Sweeps every input combination onto a combinational gate,|
// |               waits a settle time, samples the gate output and checks  |
// |               it against a truth table. Reports error count, first     |
// |               failing vector and a pass flag.                          |
// |               Optional macro GATE_TRUTH_CHECKER_STOP_ON_FAIL_EN ends   |
// |               the sweep at the first mismatching vector.               |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module gate_truth_checker
   import gate_check_pkg::*;
#(
   parameter int                    N_IN   = 2,
   parameter int                    SETTLE = 2,
   parameter logic [(2**N_IN)-1:0]  TRUTH  = 4'b1110
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            dut_z,
   output logic [N_IN-1:0] stim,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_cnt,
   output logic [N_IN-1:0] fail_vec,
   output logic            fail_vld
);

   // Counter only needs to hold SETTLE-1; keep at least one bit
   localparam int              c_cnt_w      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [c_cnt_w-1:0] c_settle_init = c_cnt_w'(SETTLE - 1);
   localparam logic [N_IN-1:0] c_last_vec   = '1;

`ifdef GATE_TRUTH_CHECKER_STOP_ON_FAIL_EN
   localparam logic c_stop_on_fail = 1'b1;
`else
   localparam logic c_stop_on_fail = 1'b0;
`endif

   state_t            r_state;
   state_t            w_state_nxt;
   logic [N_IN-1:0]   r_stim;
   logic [N_IN:0]     r_err_cnt;
   logic [N_IN-1:0]   r_fail_vec;
   logic              r_fail_vld;
   logic              r_pass;
   logic              w_load;
   logic              w_dec;
   logic              w_zero;
   logic              w_mismatch;

   // Gate output is used directly: it is a combinational function of stim
   assign w_mismatch = (dut_z != TRUTH[r_stim]);

   settle_timer #(
      .WIDTH    (c_cnt_w)
   ) u_settle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_load),
      .load_val (c_settle_init),
      .dec      (w_dec),
      .zero     (w_zero)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and settle-timer control
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_dec       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (w_zero) begin
               w_state_nxt = ST_CHECK;
            end else begin
               w_dec = 1'b1;
            end
         end
         ST_CHECK: begin
            if ((r_stim == c_last_vec) || (c_stop_on_fail && w_mismatch)) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_load      = 1'b1;
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Stimulus and result datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stim     <= '0;
         r_err_cnt  <= '0;
         r_fail_vec <= '0;
         r_fail_vld <= 1'b0;
         r_pass     <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_stim     <= '0;
                  r_err_cnt  <= '0;
                  r_fail_vec <= '0;
                  r_fail_vld <= 1'b0;
                  r_pass     <= 1'b0;
               end
            end
            ST_CHECK: begin
               if (w_mismatch) begin
                  r_err_cnt <= r_err_cnt + 1'b1;
                  if (!r_fail_vld) begin
                     r_fail_vec <= r_stim;
                     r_fail_vld <= 1'b1;
                  end
               end
               // Stim only advances when another vector follows; it freezes otherwise
               if (w_state_nxt == ST_SETTLE) begin
                  r_stim <= r_stim + 1'b1;
               end
            end
            ST_DONE: begin
               r_pass <= (r_err_cnt == '0);
            end
            default: begin
            end
         endcase
      end
   end

   assign stim     = r_stim;
   assign busy     = (r_state != ST_IDLE);
   assign done     = (r_state == ST_DONE);
   assign pass     = r_pass;
   assign err_cnt  = r_err_cnt;
   assign fail_vec = r_fail_vec;
   assign fail_vld = r_fail_vld;

endmodule : gate_truth_checker
`default_nettype wire
